wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: REG_WIDTH, default 32, datapath width; SHALL be 32 in this release.
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 Ports, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge active
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage offers an instruction
- in_ready  out  1  stage can accept
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- in_alu_result  in  REG_WIDTH  ALU result
- in_load_word  in  REG_WIDTH  aligned memory word
- in_pc_plus4  in  REG_WIDTH  link value
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  in  2  load byte offset
- hold  in  1  freeze writeback (hazard/debug)
- rd  out  5  regfile destination
- rd_din  out  REG_WIDTH  regfile write data
- reg_write  out  1  regfile write enable
- misalign_err  out  1  one-cycle pulse, misaligned load retired
- instret  out  64  retired-instruction count
- fwd_rs1, fwd_rs2  in  5 each  decode-stage source registers
- fwd_rs1_hit, fwd_rs2_hit  out  1 each  bypass select
- fwd_data  out  REG_WIDTH  bypass value

Function
REQ-004 Single-entry pipeline register (valid_q plus payload); in_ready = !valid_q || !hold.
REQ-005 Transfer occurs on a rising edge with in_valid && in_ready; payload captured; valid_q set.
REQ-006 valid_q && !hold with no new transfer: entry retires at that edge; valid_q cleared.
REQ-007 Simultaneous retire and transfer: new entry replaces old; valid_q stays 1; no bubble.
REQ-008 hold=1: entry retained; reg_write=0; in_ready=!valid_q; instret frozen.
REQ-009 Latency: transfer at edge N drives reg_write in cycle N..N+1; regfile write occurs at edge N+1 if hold=0.
REQ-010 rd_din is computed before capture and registered: ALU or PC+4 passed through; loads extracted per in_funct3/in_addr_lo (byte = word[8*off+:8], half = word[16*off[1]+:16]), sign- or zero-extended.
REQ-011 Misaligned load: LH/LHU with off[0]=1, or LW with off!=0 — captured write suppressed; misalign_err pulses for the retire cycle.
REQ-012 reg_write = valid_q && !hold && captured write enable, where write enable = in_reg_write && in_rd!=0 && in_wb_sel!=11 && !misaligned.
REQ-013 instret increments by 1 on every retire edge, including suppressed writes; 64-bit wrap from all-ones to 0.
REQ-014 rd and rd_din hold the last captured values while valid_q=0; reg_write=0 then.
REQ-015 Unlisted in_funct3 with in_wb_sel=01: treated as LW.

Reset
REQ-016 rst_n low: valid_q=0, rd=0, rd_din=0, reg_write=0, misalign_err=0, instret=0, fwd_* outputs 0, immediately and asynchronously.
REQ-017 Reset mid-operation: held entry discarded, never written; first transfer after release behaves as from empty.

Configuration
REQ-018 Macro WB_FWD_EN defined: fwd_rsX_hit = reg_write && rd==fwd_rsX; fwd_data = rd_din (covers the regfile's lack of internal forwarding).
REQ-019 WB_FWD_EN undefined: ports remain; fwd_rs1_hit, fwd_rs2_hit, fwd_data tied 0.

Verification
REQ-020 ALU: in_wb_sel=00, rd=5, alu=0x1234_5678, hold=0 -> next cycle reg_write=1, rd=5, rd_din=0x1234_5678; instret 0->1.
REQ-021 LB off=3, word=0x80FF_0000 -> rd_din=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU off=2 -> 0x0000_80FF.
REQ-022 LW off=1, rd=7 -> reg_write=0, misalign_err=1 for one cycle, instret increments.
REQ-023 hold=1 for 3 cycles with entry valid -> reg_write=0, in_ready=0, instret constant; release -> single write, back-to-back transfers then flow at 1/cycle.
REQ-024 rd=0 with in_reg_write=1 -> reg_write=0; with WB_FWD_EN, rd=9 and fwd_rs2=9 -> fwd_rs2_hit=1, fwd_data=rd_din; without macro -> 0.
REQ-025 rst_n low while entry valid -> outputs zero immediately; no write after release.

Source files
------------

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage -- writeback pipeline stage.
//
// Holds one retiring instruction. The write data is selected and load-extracted
// before capture, so the registered payload drives the register file directly.
// It also keeps the 64-bit retired-instruction counter and offers a bypass to
// decode.
//
// Optional feature (macro WB_FWD_EN): when defined, the stage drives the bypass
// outputs from the entry being written this cycle. This covers a register file
// that has no internal write-to-read forwarding. When undefined, the bypass
// outputs are tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready handshake with the MEM stage
//   in_rd, in_reg_write, in_wb_sel, in_alu_result, in_load_word,
//   in_pc_plus4, in_funct3, in_addr_lo
//                     instruction payload from MEM
//   hold              freeze writeback; the held entry is retained
//   rd, rd_din, reg_write
//                     register file write port
//   misalign_err      pulse while a misaligned load retires
//   instret           retired-instruction count
//   fwd_rs1, fwd_rs2  decode-stage source registers
//   fwd_rs1_hit, fwd_rs2_hit, fwd_data
//                     bypass select and bypass value
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic [1:0]           in_wb_sel,
    input  logic [REG_WIDTH-1:0] in_alu_result,
    input  logic [REG_WIDTH-1:0] in_load_word,
    input  logic [REG_WIDTH-1:0] in_pc_plus4,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 hold,
    output logic [4:0]           rd,
    output logic [REG_WIDTH-1:0] rd_din,
    output logic                 reg_write,
    output logic                 misalign_err,
    output logic [63:0]          instret,
    input  logic [4:0]           fwd_rs1,
    input  logic [4:0]           fwd_rs2,
    output logic                 fwd_rs1_hit,
    output logic                 fwd_rs2_hit,
    output logic [REG_WIDTH-1:0] fwd_data
);

    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelLoad = 2'b01;
    localparam logic [1:0] SelPc4  = 2'b10;
    localparam logic [1:0] SelRsvd = 2'b11;

    logic                 valid_q;
    logic [4:0]           rd_q;
    logic [REG_WIDTH-1:0] din_q;
    logic                 we_q;
    logic                 mis_q;
    logic [63:0]          instret_q;

    logic                 transfer;
    logic                 retire;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [REG_WIDTH-1:0] load_val;
    logic                 ld_is_half;
    logic                 ld_is_word;
    logic                 mis_d;
    logic [REG_WIDTH-1:0] din_d;
    logic                 we_d;

    assign in_ready = !valid_q || !hold;
    assign transfer = in_valid && in_ready;
    assign retire   = valid_q && !hold;

    // Load extraction; funct3 codes other than the five listed behave as LW.
    always_comb begin
        ld_byte    = in_load_word[{in_addr_lo, 3'b000} +: 8];
        ld_half    = in_load_word[{in_addr_lo[1], 4'b0000} +: 16];
        ld_is_half = 1'b0;
        ld_is_word = 1'b0;
        unique case (in_funct3)
            3'b000:  load_val = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {{(REG_WIDTH-8){1'b0}}, ld_byte};
            3'b001: begin
                load_val   = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
                ld_is_half = 1'b1;
            end
            3'b101: begin
                load_val   = {{(REG_WIDTH-16){1'b0}}, ld_half};
                ld_is_half = 1'b1;
            end
            default: begin
                load_val   = in_load_word;
                ld_is_word = 1'b1;
            end
        endcase
    end

    always_comb begin
        mis_d = (in_wb_sel == SelLoad) &&
                ((ld_is_half && in_addr_lo[0]) || (ld_is_word && (in_addr_lo != 2'b00)));
        unique case (in_wb_sel)
            SelAlu:  din_d = in_alu_result;
            SelLoad: din_d = load_val;
            SelPc4:  din_d = in_pc_plus4;
            SelRsvd: din_d = '0;
            default: din_d = '0;
        endcase
        we_d = in_reg_write && (in_rd != 5'd0) && (in_wb_sel != SelRsvd) && !mis_d;
    end

    // A new transfer wins over retirement, so retire+transfer keeps valid_q set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rd_q      <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            if (transfer) begin
                valid_q <= 1'b1;
                rd_q    <= in_rd;
                din_q   <= din_d;
                we_q    <= we_d;
                mis_q   <= mis_d;
            end else if (retire) begin
                valid_q <= 1'b0;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign rd           = rd_q;
    assign rd_din       = din_q;
    assign reg_write    = retire && we_q;
    assign misalign_err = retire && mis_q;
    assign instret      = instret_q;

`ifdef WB_FWD_EN
    assign fwd_rs1_hit = reg_write && (rd_q == fwd_rs1);
    assign fwd_rs2_hit = reg_write && (rd_q == fwd_rs2);
    assign fwd_data    = din_q;
`else
    logic unused_fwd;
    assign unused_fwd  = ^{fwd_rs1, fwd_rs2};
    assign fwd_rs1_hit = 1'b0;
    assign fwd_rs2_hit = 1'b0;
    assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Stimulus pushes the expected register-file writes (or misalign pulses) into a
// queue; a monitor on the falling edge pops one entry for each output event.
// ----------------------------------------------------------------------------
module tb_wb_stage;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] din;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_load_word = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        hold = 1'b0;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        reg_write;
    logic        misalign_err;
    logic [63:0] instret;
    logic [4:0]  fwd_rs1 = '0;
    logic [4:0]  fwd_rs2 = '0;
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_data;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [63:0] exp_instret = '0;

    wb_stage #(.REG_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .in_wb_sel    (in_wb_sel),
        .in_alu_result(in_alu_result),
        .in_load_word (in_load_word),
        .in_pc_plus4  (in_pc_plus4),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .hold         (hold),
        .rd           (rd),
        .rd_din       (rd_din),
        .reg_write    (reg_write),
        .misalign_err (misalign_err),
        .instret      (instret),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_data     (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write or misalign pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (reg_write || misalign_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {62'd0, reg_write, misalign_err}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_reg_write", {63'd0, reg_write}, {63'd0, !e.mis});
                chk("mon_misalign", {63'd0, misalign_err}, {63'd0, e.mis});
                chk("mon_rd", {59'd0, rd}, {59'd0, e.rd});
                if (!e.mis) chk("mon_rd_din", {32'd0, rd_din}, {32'd0, e.din});
            end
        end
    end

    task automatic exp_wr(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rd = r; e.din = d; e.mis = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_mis(input logic [4:0] r);
        exp_t e;
        e.rd = r; e.din = '0; e.mis = 1'b1;
        sb.push_back(e);
    endtask

    // Called at posedge+1; presents one entry for one edge (in_ready assumed).
    task automatic send(input logic [4:0] r, input logic rw, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] word,
                        input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] off);
        in_valid = 1'b1; in_rd = r; in_reg_write = rw; in_wb_sel = sel;
        in_alu_result = alu; in_load_word = word; in_pc_plus4 = pc;
        in_funct3 = f3; in_addr_lo = off;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_instret = exp_instret + 64'd1;
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_instret"}, instret, exp_instret);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    localparam logic [31:0] W = 32'h80FF_0000;

    initial begin
        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_rd_din", {32'd0, rd_din}, 64'd0);
        chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_fwd", {31'd0, fwd_data, fwd_rs1_hit, fwd_rs2_hit}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU writeback.
        exp_wr(5'd5, 32'h1234_5678);
        send(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 3'b000, 2'b00);
        drain("alu");

        // Loads and PC+4, issued back to back.
        exp_wr(5'd1, 32'hFFFF_FF80);
        send(5'd1, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b000, 2'd3);   // LB  off 3
        exp_wr(5'd2, 32'h0000_0080);
        send(5'd2, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b100, 2'd3);   // LBU off 3
        exp_wr(5'd3, 32'h0000_80FF);
        send(5'd3, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b101, 2'd2);   // LHU off 2
        exp_wr(5'd4, 32'hFFFF_80FF);
        send(5'd4, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b001, 2'd2);   // LH  off 2
        exp_wr(5'd6, 32'hFFFF_FFFF);
        send(5'd6, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b000, 2'd2);   // LB  off 2
        exp_wr(5'd8, 32'h0000_0000);
        send(5'd8, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b100, 2'd0);   // LBU off 0
        exp_wr(5'd10, 32'h80FF_0000);
        send(5'd10, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b010, 2'd0);  // LW
        exp_wr(5'd11, 32'h80FF_0000);
        send(5'd11, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b011, 2'd0);  // unlisted -> LW
        exp_wr(5'd12, 32'h0000_1004);
        send(5'd12, 1'b1, 2'b10, 32'hDEAD_BEEF, W, 32'h0000_1004, 3'b000, 2'd0);
        drain("loads");

        // Misaligned loads: no write, misalign pulse, instret still counts.
        exp_mis(5'd7);
        send(5'd7, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b010, 2'd1);   // LW off 1
        exp_mis(5'd13);
        send(5'd13, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b001, 2'd3);  // LH off 3
        exp_wr(5'd14, 32'h0000_80FF);
        send(5'd14, 1'b1, 2'b01, 32'h0, W, 32'h0, 3'b101, 2'd2);  // LHU off 2 ok
        drain("misalign");

        // Suppressed writes: rd 0, reserved select, reg_write clear.
        send(5'd0, 1'b1, 2'b00, 32'h1111_1111, 32'h0, 32'h0, 3'b000, 2'd0);
        send(5'd3, 1'b1, 2'b11, 32'h2222_2222, 32'h0, 32'h0, 3'b000, 2'd0);
        send(5'd4, 1'b0, 2'b00, 32'h3333_3333, 32'h0, 32'h0, 3'b000, 2'd0);
        drain("suppress");

        // Hold with a valid entry, then release into back-to-back flow.
        hold = 1'b1;
        exp_wr(5'd15, 32'hA000_0001);
        send(5'd15, 1'b1, 2'b00, 32'hA000_0001, 32'h0, 32'h0, 3'b000, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_reg_write", {63'd0, reg_write}, 64'd0);
            chk("hold_instret", instret, exp_instret - 64'd1);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        exp_wr(5'd16, 32'hA000_0002);
        send(5'd16, 1'b1, 2'b00, 32'hA000_0002, 32'h0, 32'h0, 3'b000, 2'd0);
        exp_wr(5'd17, 32'hA000_0003);
        send(5'd17, 1'b1, 2'b00, 32'hA000_0003, 32'h0, 32'h0, 3'b000, 2'd0);
        exp_wr(5'd18, 32'hA000_0004);
        send(5'd18, 1'b1, 2'b00, 32'hA000_0004, 32'h0, 32'h0, 3'b000, 2'd0);
        // Last entry is retiring now; at 1/cycle every older one is already gone.
        chk("flow_sb_depth", 64'(sb.size()), 64'd1);
        drain("hold");

        // Bypass.
        fwd_rs1 = 5'd4;
        fwd_rs2 = 5'd9;
        exp_wr(5'd9, 32'hCAFE_F00D);
        send(5'd9, 1'b1, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h0, 3'b000, 2'd0);
`ifdef WB_FWD_EN
        chk("fwd_rs2_hit", {63'd0, fwd_rs2_hit}, 64'd1);
        chk("fwd_data", {32'd0, fwd_data}, 64'h0000_0000_CAFE_F00D);
`else
        chk("fwd_rs2_hit", {63'd0, fwd_rs2_hit}, 64'd0);
        chk("fwd_data", {32'd0, fwd_data}, 64'd0);
`endif
        chk("fwd_rs1_hit", {63'd0, fwd_rs1_hit}, 64'd0);
        drain("fwd");

        // Reset while a held entry is valid: discarded, never written.
        hold = 1'b1;
        send(5'd20, 1'b1, 2'b00, 32'hBAD0_BAD0, 32'h0, 32'h0, 3'b000, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_reg_write", {63'd0, reg_write}, 64'd0);
        chk("midrst_rd", {59'd0, rd}, 64'd0);
        chk("midrst_rd_din", {32'd0, rd_din}, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold = 1'b0;
        exp_instret = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_instret", instret, 64'd0);
        exp_wr(5'd21, 32'h0BAD_F00D);
        send(5'd21, 1'b1, 2'b00, 32'h0BAD_F00D, 32'h0, 32'h0, 3'b000, 2'd0);
        drain("postrst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
